// File: rtl/flp_dp_accum.sv
// flp_dp_accum: accumulates CHUNKS FP32 partial dot products into one FP32 vector sum.
// Build option ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the adder truncates toward zero.
module flp_dp_accum #(
    parameter int CHUNKS = 4,
    parameter int CNT_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    input  logic [31:0] z_in_i,
    input  logic        clear_i,
    output logic        out_valid_o,
    output logic [31:0] sum_out_o,
    output logic        busy_o,
    output logic        ovf_o
);

`ifdef ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        sum_out_q, sum_out_d;

    logic               a_inf, b_inf;
    logic [30:0]        a_mag, b_mag, l_mag, s_mag;
    logic               l_sign, s_sign;
    logic [26:0]        l_man, s_man, s_al, lost_mask;
    logic [7:0]         exp_diff;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic [26:0]        norm;
    logic signed [9:0]  exp_n;
    logic               rnd_up;
    logic [24:0]        man_r;
    logic [22:0]        frac_r;
    logic [31:0]        add_res;
    logic               add_ovf;

    // Single-cycle FP32 adder: acc_q + z_in_i, subnormals flushed, 27-bit datapath (24 + G/R/S).
    always_comb begin
        a_inf = &acc_q[30:23];
        b_inf = &z_in_i[30:23];
        a_mag = (acc_q[30:23] == 8'd0) ? 31'd0 : acc_q[30:0];
        b_mag = (z_in_i[30:23] == 8'd0) ? 31'd0 : z_in_i[30:0];

        if (b_mag > a_mag) begin
            l_mag  = b_mag;
            l_sign = z_in_i[31];
            s_mag  = a_mag;
            s_sign = acc_q[31];
        end else begin
            l_mag  = a_mag;
            l_sign = acc_q[31];
            s_mag  = b_mag;
            s_sign = z_in_i[31];
        end

        l_man     = {(l_mag[30:23] != 8'd0), l_mag[22:0], 3'b000};
        s_man     = {(s_mag[30:23] != 8'd0), s_mag[22:0], 3'b000};
        exp_diff  = l_mag[30:23] - s_mag[30:23];
        lost_mask = (27'd1 << exp_diff) - 27'd1;
        if (exp_diff >= 8'd27) begin
            s_al = {26'd0, |s_man};
        end else begin
            s_al = (s_man >> exp_diff) | {26'd0, |(s_man & lost_mask)};
        end

        if (l_sign == s_sign) begin
            sum = {1'b0, l_man} + {1'b0, s_al};
        end else begin
            sum = {1'b0, l_man} - {1'b0, s_al};
        end

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) begin
                lz = 5'(26 - i);
            end
        end

        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, l_mag[30:23]}) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = $signed({2'b00, l_mag[30:23]}) - $signed({5'd0, lz});
        end

        rnd_up = RNE & norm[2] & (norm[3] | norm[1] | norm[0]);
        man_r  = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        if (man_r[24]) begin
            frac_r = man_r[23:1];
            exp_n  = exp_n + 10'sd1;
        end else begin
            frac_r = man_r[22:0];
        end

        add_ovf = 1'b0;
        if (a_inf && b_inf && (acc_q[31] != z_in_i[31])) begin
            add_res = 32'h7FC0_0000;
        end else if (a_inf) begin
            add_res = {acc_q[31], 8'hFF, 23'd0};
        end else if (b_inf) begin
            add_res = {z_in_i[31], 8'hFF, 23'd0};
        end else if (sum == 28'd0 || exp_n <= 10'sd0) begin
            add_res = 32'd0;
        end else if (exp_n >= 10'sd255) begin
            add_res = {l_sign, 8'hFF, 23'd0};
            add_ovf = 1'b1;
        end else begin
            add_res = {l_sign, exp_n[7:0], frac_r};
        end
    end

    // Next-state logic; clear overrides the FSM and may itself start a new vector.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        sum_out_d   = sum_out_q;

        if (clear_i) begin
            acc_d   = 32'd0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
            if (in_valid_i) begin
                acc_d   = z_in_i;
                cnt_d   = ONE_CNT;
                state_d = (CHUNKS == 1) ? DONE : ACC;
            end
        end else begin
            case (state_q)
                ACC: begin
                    if (in_valid_i) begin
                        acc_d = add_res;
                        ovf_d = ovf_q | add_ovf;
                        cnt_d = cnt_q + ONE_CNT;
                        if (cnt_q == LAST_CNT) begin
                            state_d = DONE;
                        end
                    end
                end
                default: begin
                    if (state_q == DONE) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                    if (in_valid_i) begin
                        acc_d   = z_in_i;
                        cnt_d   = ONE_CNT;
                        state_d = (CHUNKS == 1) ? DONE : ACC;
                    end
                end
            endcase
        end

        if (state_d == DONE) begin
            out_valid_d = 1'b1;
            sum_out_d   = acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= 32'd0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sum_out_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            sum_out_q   <= sum_out_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign sum_out_o   = sum_out_q;
    assign busy_o      = (state_q == ACC);
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_flp_dp_accum.sv
// Directed-vector bench for flp_dp_accum (CHUNKS=4); expected sums are hand-computed FP32 constants.
module tb_flp_dp_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] z_in;
    logic        clear;
    logic        out_valid;
    logic [31:0] sum_out;
    logic        busy;
    logic        ovf;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          pulses   = 0;
    int          pulse_cyc [4];
    logic [31:0] pulse_sum [4];

    flp_dp_accum #(.CHUNKS(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .z_in_i      (z_in),
        .clear_i     (clear),
        .out_valid_o (out_valid),
        .sum_out_o   (sum_out),
        .busy_o      (busy),
        .ovf_o       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one cycle of input and observe outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic [31:0] z);
        in_valid = v;
        z_in     = z;
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) begin
            if (pulses < 4) begin
                pulse_cyc[pulses] = cyc + 1;
                pulse_sum[pulses] = sum_out;
            end
            pulses++;
            $display("vector done: cycle %0d sum=%h ovf=%b", cyc + 1, sum_out, ovf);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; z_in = 32'd0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (sum_out !== 32'd0) $display("FAIL reset_sum: got %h expected 00000000", sum_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else n_pass++;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ones();
        step(1'b1, 32'h3F80_0000);
        n_checks++; if (busy !== 1'b1) $display("FAIL ones_busy: got %b expected 1", busy); else n_pass++;
        repeat (3) step(1'b1, 32'h3F80_0000);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL ones_valid: got %b expected 1", out_valid); else n_pass++;
        n_checks++; if (sum_out !== 32'h4080_0000) $display("FAIL ones_sum: got %h expected 40800000", sum_out); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL ones_ovf: got %b expected 0", ovf); else n_pass++;
        step(1'b0, 32'd0);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL ones_pulse_end: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (sum_out !== 32'h4080_0000) $display("FAIL ones_sum_hold: got %h expected 40800000", sum_out); else n_pass++;
    endtask

    task automatic test_gaps();
        logic [31:0] vals [4];
        vals = '{32'h3F80_0000, 32'h4000_0000, 32'hC040_0000, 32'h3F00_0000};
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vals[i]);
            if (i < 3) begin
                repeat (2) step(1'b0, 32'd0);
            end
        end
        n_checks++; if (out_valid !== 1'b1) $display("FAIL gaps_valid: got %b expected 1", out_valid); else n_pass++;
        n_checks++; if (sum_out !== 32'h3F00_0000) $display("FAIL gaps_sum: got %h expected 3F000000", sum_out); else n_pass++;
        repeat (3) step(1'b0, 32'd0);
        n_checks++; if (pulses !== 1) $display("FAIL gaps_pulse_count: got %0d expected 1", pulses); else n_pass++;
    endtask

    task automatic test_overflow();
        repeat (4) step(1'b1, 32'h7F7F_FFFF);
        n_checks++; if (sum_out !== 32'h7F80_0000) $display("FAIL ovf_sum: got %h expected 7F800000", sum_out); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", ovf); else n_pass++;
        repeat (4) step(1'b1, 32'h3F80_0000);
        n_checks++; if (sum_out !== 32'h4080_0000) $display("FAIL ovf_next_sum: got %h expected 40800000", sum_out); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", ovf); else n_pass++;
        clear = 1'b1;
        step(1'b0, 32'd0);
        clear = 1'b0;
        n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", ovf); else n_pass++;
    endtask

    task automatic test_back_to_back();
        pulses = 0;
        cyc    = 0;
        repeat (4) step(1'b1, 32'h3F80_0000);
        repeat (4) step(1'b1, 32'h4000_0000);
        step(1'b0, 32'd0);
        n_checks++; if (pulses !== 2) $display("FAIL b2b_pulse_count: got %0d expected 2", pulses); else n_pass++;
        n_checks++; if (pulse_cyc[0] !== 5) $display("FAIL b2b_cycle0: got %0d expected 5", pulse_cyc[0]); else n_pass++;
        n_checks++; if (pulse_cyc[1] !== 9) $display("FAIL b2b_cycle1: got %0d expected 9", pulse_cyc[1]); else n_pass++;
        n_checks++; if (pulse_sum[0] !== 32'h4080_0000) $display("FAIL b2b_sum0: got %h expected 40800000", pulse_sum[0]); else n_pass++;
        n_checks++; if (pulse_sum[1] !== 32'h4100_0000) $display("FAIL b2b_sum1: got %h expected 41000000", pulse_sum[1]); else n_pass++;
    endtask

    task automatic test_async_reset();
        repeat (2) step(1'b1, 32'h3F80_0000);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (sum_out !== 32'd0) $display("FAIL arst_sum: got %h expected 00000000", sum_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", out_valid); else n_pass++;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) step(1'b1, 32'h3F80_0000);
        n_checks++; if (sum_out !== 32'h4080_0000) $display("FAIL arst_next_sum: got %h expected 40800000", sum_out); else n_pass++;
        step(1'b0, 32'd0);
    endtask

    task automatic test_clear();
        pulses = 0;
        repeat (2) step(1'b1, 32'h3F80_0000);
        clear = 1'b1;
        step(1'b0, 32'd0);
        clear = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL clear_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (pulses !== 0) $display("FAIL clear_no_pulse: got %0d expected 0", pulses); else n_pass++;
        repeat (4) step(1'b1, 32'h3F80_0000);
        n_checks++; if (sum_out !== 32'h4080_0000) $display("FAIL clear_next_sum: got %h expected 40800000", sum_out); else n_pass++;
        step(1'b0, 32'd0);
        repeat (2) step(1'b1, 32'h3F80_0000);
        clear = 1'b1;
        step(1'b1, 32'h4000_0000);
        clear = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL clear_load_busy: got %b expected 1", busy); else n_pass++;
        repeat (3) step(1'b1, 32'h3F80_0000);
        n_checks++; if (sum_out !== 32'h40A0_0000) $display("FAIL clear_load_sum: got %h expected 40A00000", sum_out); else n_pass++;
        step(1'b0, 32'd0);
    endtask

    task automatic test_rounding();
        logic [31:0] exp_sum;
`ifdef ROUND_NEAREST_EN
        exp_sum = 32'h3F80_0001;
`else
        exp_sum = 32'h3F80_0000;
`endif
        step(1'b1, 32'h3F80_0000);
        step(1'b1, 32'h33C0_0000);
        step(1'b1, 32'h0000_0000);
        step(1'b1, 32'h0000_0000);
        n_checks++; if (sum_out !== exp_sum) $display("FAIL round_sum: got %h expected %h", sum_out, exp_sum); else n_pass++;
        step(1'b0, 32'd0);
    endtask

    task automatic test_normalise();
        // 3 - 1 + 0.25 + subnormal(flushed) = 2.25
        step(1'b1, 32'h4040_0000);
        step(1'b1, 32'hBF80_0000);
        step(1'b1, 32'h3E80_0000);
        step(1'b1, 32'h0040_0000);
        n_checks++; if (sum_out !== 32'h4010_0000) $display("FAIL norm_sum: got %h expected 40100000", sum_out); else n_pass++;
        step(1'b0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_ones();
        test_gaps();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_clear();
        test_rounding();
        test_normalise();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
